axi4_lite: RTL and testbench

AXI4-Lite slave register block: four 32-bit word registers behind a 4-bit byte address. It drives four board LEDs from register 0 and exposes four board switches as a read-only register. It sits between an AXI4-Lite interconnect master (processor/bridge) and board I/O as a simple memory-mapped GPIO peripheral.

---
 rtl/axi4_lite.sv | 148 ++++++++++++++
 tb/tb_axi4_lite.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite.sv
// AXI4-Lite GPIO register block: reg0 drives LED, 0x4 reads switches, 0x8/0xC scratch.
// Optional SW_SYNC_EN: two-flop synchronizer on SW before it reaches the read path.
module axi4_lite #(
  parameter int AXI_Dwidth    = 32,
  parameter int AXI_Addrwidth = 4
) (
  input  logic                      AXI_aclk,
  input  logic                      AXI_areset,
  input  logic [AXI_Addrwidth-1:0]  AXI_awaddr,
  input  logic                      AXI_awvalid,
  output logic                      AXI_awready,
  input  logic [AXI_Dwidth-1:0]     AXI_wdata,
  input  logic [AXI_Dwidth/8-1:0]   AXI_wstrb,
  input  logic                      AXI_wvalid,
  output logic                      AXI_wready,
  output logic [1:0]                AXI_bresp,
  output logic                      AXI_bvalid,
  input  logic                      AXI_bready,
  input  logic [AXI_Addrwidth-1:0]  AXI_areadaddr,
  input  logic [2:0]                AXI_arprotect,
  input  logic                      AXI_arvalid,
  output logic                      AXI_arready,
  output logic [AXI_Dwidth-1:0]     AXI_rdata,
  output logic [1:0]                AXI_rresp,
  output logic                      AXI_rvalid,
  input  logic                      AXI_rready,
  output logic [3:0]                LED,
  input  logic [3:0]                SW
);

  localparam int NB = AXI_Dwidth / 8;

  logic                  wr_ack_q, wr_ack_d;
  logic                  bvalid_q, bvalid_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [AXI_Dwidth-1:0] rdata_q, rdata_d;
  logic [AXI_Dwidth-1:0] reg0_q, reg0_d;
  logic [AXI_Dwidth-1:0] reg2_q, reg2_d;
  logic [AXI_Dwidth-1:0] reg3_q, reg3_d;
  logic [3:0]            sw_status;
  logic                  wr_fire, rd_fire;
  logic                  unused_bits;

  assign unused_bits = ^{AXI_arprotect, AXI_awaddr[1:0], AXI_areadaddr[1:0]};

`ifdef SW_SYNC_EN
  logic [3:0] sw_meta_q, sw_sync_q;
  always_ff @(posedge AXI_aclk) begin
    if (AXI_areset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
    end
  end
  assign sw_status = sw_sync_q;
`else
  assign sw_status = SW;
`endif

  function automatic logic [AXI_Dwidth-1:0] merge_lanes(
    input logic [AXI_Dwidth-1:0] old_val,
    input logic [AXI_Dwidth-1:0] new_val,
    input logic [NB-1:0]         strb
  );
    logic [AXI_Dwidth-1:0] res;
    res = old_val;
    for (int i = 0; i < NB; i++)
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    return res;
  endfunction

  // Handshake edges: ready flops were raised one cycle earlier, valids still held.
  assign wr_fire = wr_ack_q && AXI_awvalid && AXI_wvalid;
  assign rd_fire = arready_q && AXI_arvalid;

  always_comb begin
    wr_ack_d = AXI_awvalid && AXI_wvalid && !wr_ack_q && !bvalid_q;
    bvalid_d = bvalid_q;
    if (wr_fire)                      bvalid_d = 1'b1;
    else if (bvalid_q && AXI_bready)  bvalid_d = 1'b0;

    reg0_d = reg0_q;
    reg2_d = reg2_q;
    reg3_d = reg3_q;
    if (wr_fire) begin
      case (AXI_awaddr[3:2])
        2'd0:    reg0_d = merge_lanes(reg0_q, AXI_wdata, AXI_wstrb);
        2'd2:    reg2_d = merge_lanes(reg2_q, AXI_wdata, AXI_wstrb);
        2'd3:    reg3_d = merge_lanes(reg3_q, AXI_wdata, AXI_wstrb);
        default: ;
      endcase
    end
  end

  // Read mux uses current register values, so a coincident write is not visible yet.
  always_comb begin
    arready_d = AXI_arvalid && !arready_q && !rvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      case (AXI_areadaddr[3:2])
        2'd0:    rdata_d = reg0_q;
        2'd1:    rdata_d = {{(AXI_Dwidth-4){1'b0}}, sw_status};
        2'd2:    rdata_d = reg2_q;
        default: rdata_d = reg3_q;
      endcase
    end else if (rvalid_q && AXI_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge AXI_aclk) begin
    if (AXI_areset) begin
      wr_ack_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      reg0_q    <= '0;
      reg2_q    <= '0;
      reg3_q    <= '0;
    end else begin
      wr_ack_q  <= wr_ack_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      reg0_q    <= reg0_d;
      reg2_q    <= reg2_d;
      reg3_q    <= reg3_d;
    end
  end

  assign AXI_awready = wr_ack_q;
  assign AXI_wready  = wr_ack_q;
  assign AXI_bvalid  = bvalid_q;
  assign AXI_bresp   = 2'b00;
  assign AXI_arready = arready_q;
  assign AXI_rvalid  = rvalid_q;
  assign AXI_rdata   = rdata_q;
  assign AXI_rresp   = 2'b00;
  assign LED         = reg0_q[3:0];

endmodule

// File: tb/tb_axi4_lite.sv
// Directed bench for axi4_lite: vector table of single transactions plus hand-written
// sequences for backpressure, coincident read/write and reset with responses pending.
module tb_axi4_lite;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr, araddr, wstrb, led, sw;
  logic [31:0] wdata, rdata;
  logic [2:0]  arprot;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi4_lite dut (
    .AXI_aclk(clk), .AXI_areset(rst),
    .AXI_awaddr(awaddr), .AXI_awvalid(awvalid), .AXI_awready(awready),
    .AXI_wdata(wdata), .AXI_wstrb(wstrb), .AXI_wvalid(wvalid), .AXI_wready(wready),
    .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready),
    .AXI_areadaddr(araddr), .AXI_arprotect(arprot), .AXI_arvalid(arvalid),
    .AXI_arready(arready), .AXI_rdata(rdata), .AXI_rresp(rresp), .AXI_rvalid(rvalid),
    .AXI_rready(rready), .LED(led), .SW(sw)
  );

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  sw;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_led;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [3:0] exp_led);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 8);
    chk("wr_awready_latency", n, 1);
    chk("wr_wready_with_awready", wready, 1);
    chk("wr_bvalid_not_early", bvalid, 0);
    @(negedge clk);
    chk("wr_awready_pulse", awready, 0);
    chk("wr_bvalid", bvalid, 1);
    chk("wr_bresp", bresp, 0);
    chk("wr_led_at_handshake", led, exp_led);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("wr_bvalid_clear", bvalid, 0);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 8);
    chk("rd_arready_latency", n, 1);
    @(negedge clk);
    chk("rd_arready_pulse", arready, 0);
    chk("rd_rvalid", rvalid, 1);
    chk("rd_rdata", rdata, exp);
    chk("rd_rresp", rresp, 0);
    arvalid = 1'b0;
    @(negedge clk);
    chk("rd_rvalid_clear", rvalid, 0);
    rready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'h0, 32'hADDBCFFE, 4'hF, 4'h0, 32'h0,        4'hE};
    vecs[1]  = '{1'b0, 4'h0, 32'h0,        4'h0, 4'h0, 32'hADDBCFFE, 4'hE};
    vecs[2]  = '{1'b1, 4'h8, 32'h12345678, 4'hF, 4'h0, 32'h0,        4'hE};
    vecs[3]  = '{1'b1, 4'h8, 32'h000000AB, 4'h1, 4'h0, 32'h0,        4'hE};
    vecs[4]  = '{1'b0, 4'h8, 32'h0,        4'h0, 4'h0, 32'h123456AB, 4'hE};
    vecs[5]  = '{1'b1, 4'hC, 32'hAABBCCDD, 4'hA, 4'h0, 32'h0,        4'hE};
    vecs[6]  = '{1'b0, 4'hC, 32'h0,        4'h0, 4'h0, 32'hAA00CC00, 4'hE};
    vecs[7]  = '{1'b0, 4'h4, 32'h0,        4'h0, 4'h9, 32'h00000009, 4'hE};
    vecs[8]  = '{1'b1, 4'h4, 32'hFFFFFFFF, 4'hF, 4'h9, 32'h0,        4'hE};
    vecs[9]  = '{1'b0, 4'h4, 32'h0,        4'h0, 4'h9, 32'h00000009, 4'hE};
    vecs[10] = '{1'b0, 4'h6, 32'h0,        4'h0, 4'h6, 32'h00000006, 4'hE};
    vecs[11] = '{1'b1, 4'h3, 32'h00000005, 4'h1, 4'h6, 32'h0,        4'h5};
    vecs[12] = '{1'b0, 4'h1, 32'h0,        4'h0, 4'h6, 32'hADDBCF05, 4'h5};

    rst = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; arprot = '0; sw = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_led", led, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      sw = vecs[i].sw;
      repeat (3) @(negedge clk);
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_led);
      else            do_read(vecs[i].addr, vecs[i].exp_rdata);
      chk("vec_led", led, vecs[i].exp_led);
    end

    // rready held low: rvalid and rdata must hold
    @(negedge clk);
    araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
    repeat (2) @(negedge clk);
    arvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("hold_rvalid", rvalid, 1);
      chk("hold_rdata", rdata, 32'hADDBCF05);
      chk("hold_no_arready", arready, 0);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    chk("hold_rvalid_clear", rvalid, 0);
    rready = 1'b0;

    // awvalid alone, then wvalid alone: never acknowledged
    awaddr = 4'h8; wdata = 32'hDEADDEAD; wstrb = 4'hF; awvalid = 1'b1; bready = 1'b1;
    for (int k = 0; k < 3; k++) begin @(negedge clk); chk("aw_only_no_ack", awready, 0); end
    awvalid = 1'b0; wvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin @(negedge clk); chk("w_only_no_ack", wready, 0); end
    wvalid = 1'b0;
    @(negedge clk);
    chk("aw_only_no_bvalid", bvalid, 0);

    // bready low: bvalid holds and a second write is stalled
    awaddr = 4'h8; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_bvalid", bvalid, 1);
    wdata = 32'hCAFE0001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_bvalid_hold", bvalid, 1);
      chk("bp_no_awready", awready, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    chk("bp_bvalid_clear", bvalid, 0);
    chk("bp_awready_not_yet", awready, 0);
    @(negedge clk);
    chk("bp_second_awready", awready, 1);
    @(negedge clk);
    chk("bp_second_bvalid", bvalid, 1);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    do_read(4'h8, 32'hCAFE0001);

    // coincident read and write handshake on 0xC returns the old value
    @(negedge clk);
    awaddr = 4'hC; wdata = 32'h11112222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'hC; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    chk("same_awready", awready, 1);
    chk("same_arready", arready, 1);
    @(negedge clk);
    chk("same_bvalid", bvalid, 1);
    chk("same_rvalid", rvalid, 1);
    chk("same_rdata_old", rdata, 32'hAA00CC00);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    rready = 1'b0;
    do_read(4'hC, 32'h11112222);

    // reset with bvalid and rvalid pending
    @(negedge clk);
    awaddr = 4'h0; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h8; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_bvalid", bvalid, 1);
    chk("pre_rst_rvalid", rvalid, 1);
    chk("pre_rst_led", led, 4'hF);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_led", led, 0);
    chk("mid_rst_ready", {awready, wready, arready}, 0);
    chk("mid_rst_resp", {bresp, rresp}, 0);
    rst = 1'b0;
    do_read(4'h0, 32'h0);
    do_read(4'hC, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
